// File: rtl/audio_stream_sequencer_if.sv
// Purpose : stereo codec FIFO handshake, filter pair and status lines bundled into one bus.
// Latency : n/a, wiring only.
// Backpressure: read/read_ready on the codec input side, write/write_ready on the codec output side.
// Ports   : codec read side (read_ready, readdata_*, read), codec write side (write_ready, write,
//           writedata_*), filter pair (filt_en, filt_d_*, filt_q_*), bypass and the two status counters.
interface audio_stream_sequencer_if #(
    parameter int DW = 24
);
    // codec input FIFO
    logic          read_ready;
    logic [DW-1:0] readdata_left;
    logic [DW-1:0] readdata_right;
    logic          read;
    // codec output FIFO
    logic          write_ready;
    logic          write;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;
    // filter pair
    logic          filt_en;
    logic [DW-1:0] filt_d_left;
    logic [DW-1:0] filt_d_right;
    logic [DW-1:0] filt_q_left;
    logic [DW-1:0] filt_q_right;
    // control / status
    logic          bypass;
    logic [15:0]   sample_count;
    logic [7:0]    drop_count;

    // environment side: codec, filters and control
    modport master (
        output read_ready, readdata_left, readdata_right,
        input  read,
        output write_ready,
        input  write, writedata_left, writedata_right,
        input  filt_en, filt_d_left, filt_d_right,
        output filt_q_left, filt_q_right,
        output bypass,
        input  sample_count, drop_count
    );

    // sequencer side
    modport slave (
        input  read_ready, readdata_left, readdata_right,
        output read,
        input  write_ready,
        output write, writedata_left, writedata_right,
        output filt_en, filt_d_left, filt_d_right,
        input  filt_q_left, filt_q_right,
        input  bypass,
        output sample_count, drop_count
    );
endinterface

// File: rtl/audio_stream_sequencer.sv
// Purpose : pops one stereo sample from the codec, pulses the filter pair once, pushes the result back.
// Latency : read at T, filt_en at T+1, earliest write at T+2 (one sample per 3 cycles at best).
// Backpressure: one sample in flight; no read until it is written or dropped after TIMEOUT stalled cycles.
// Ports   : clock, reset (sync, active-high); bus = slave side of audio_stream_sequencer_if.
module audio_stream_sequencer #(
    parameter int DW      = 24,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                      clock,
    input  logic                      reset,
    audio_stream_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILT  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } stereo_t;

    state_t        r_state;
    state_t        w_next;
    stereo_t       r_in;
    stereo_t       r_out;
    logic [TW-1:0] r_tmo;
    logic [15:0]   r_sample_cnt;
    logic [7:0]    r_drop_cnt;

    logic          w_read;
    logic          w_write;
    logic          w_filt_en;
    logic          w_tmo_hit;

    // Last permitted stall cycle; a write in this same cycle still wins.
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.read_ready) w_next = S_FILT;
            S_FILT:  w_next = S_WRITE;
            S_WRITE: if (bus.write_ready || w_tmo_hit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs; all strobes are held low while reset is high so an
    // in-flight sample is neither written nor fed to the filters.
    always_comb begin
        w_read    = 1'b0;
        w_write   = 1'b0;
        w_filt_en = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE:  w_read    = bus.read_ready;
                S_FILT:  w_filt_en = 1'b1;
                S_WRITE: w_write   = bus.write_ready;
                default: ;
            endcase
        end
    end

    // Datapath and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in         <= '0;
            r_out        <= '0;
            r_tmo        <= '0;
            r_sample_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.read_ready) begin
                        r_in.l <= bus.readdata_left;
                        r_in.r <= bus.readdata_right;
                    end
                end
                S_FILT: begin
                    // Filter q already reflects this enable, so it is captured
                    // in the pulse cycle. Bypass only chooses what is kept; the
                    // filters are pulsed either way to keep their history intact.
                    if (bus.bypass) begin
                        r_out <= r_in;
                    end else begin
                        r_out.l <= bus.filt_q_left;
                        r_out.r <= bus.filt_q_right;
                    end
                    r_tmo <= '0;
                end
                S_WRITE: begin
                    if (bus.write_ready) begin
                        r_sample_cnt <= r_sample_cnt + 16'd1;
                    end else if (w_tmo_hit) begin
                        if (r_drop_cnt != 8'hFF) begin
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                        end
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.read            = w_read;
    assign bus.write           = w_write;
    assign bus.filt_en         = w_filt_en;
    assign bus.filt_d_left     = r_in.l;
    assign bus.filt_d_right    = r_in.r;
    assign bus.writedata_left  = r_out.l;
    assign bus.writedata_right = r_out.r;
    assign bus.sample_count    = r_sample_cnt;
    assign bus.drop_count      = r_drop_cnt;

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Purpose : directed bench for audio_stream_sequencer with an accumulating filter model.
// Latency : inputs driven 1 time unit after the rising edge, outputs observed 2 units after it.
// Backpressure: write_ready is held low to force stalls, timeouts and the late-write case.
module tb_audio_stream_sequencer;

    localparam int DW = 24;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    audio_stream_sequencer_if #(.DW(DW)) bus ();

    audio_stream_sequencer #(
        .DW      (DW),
        .TIMEOUT (8),
        .TW      (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Filter model: accumulator of d>>>3; q shows the updated sum during the enable cycle.
    logic [DW-1:0] acc_l = '0;
    logic [DW-1:0] acc_r = '0;

    function automatic logic [DW-1:0] sra3(input logic [DW-1:0] d);
        return DW'($signed(d) >>> 3);
    endfunction

    assign bus.filt_q_left  = bus.filt_en ? acc_l + sra3(bus.filt_d_left)  : acc_l;
    assign bus.filt_q_right = bus.filt_en ? acc_r + sra3(bus.filt_d_right) : acc_r;

    always @(posedge clock) begin
        if (bus.filt_en) begin
            acc_l <= acc_l + sra3(bus.filt_d_left);
            acc_r <= acc_r + sra3(bus.filt_d_right);
        end
    end

    // Strobe monitor, observed on the falling edge.
    int            n_rd   = 0;
    int            n_wr   = 0;
    int            n_fe   = 0;
    int            n_both = 0;
    logic [DW-1:0] last_wl = '0;
    logic [DW-1:0] last_wr = '0;

    always @(negedge clock) begin
        if (bus.read)    n_rd++;
        if (bus.filt_en) n_fe++;
        if (bus.read && bus.write) n_both++;
        if (bus.write) begin
            n_wr++;
            last_wl = bus.writedata_left;
            last_wr = bus.writedata_right;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_mon();
        n_rd = 0; n_wr = 0; n_fe = 0; n_both = 0;
    endtask

    // One sample with write_ready high; starts and ends in S_IDLE.
    task automatic run_sample(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic bp);
        bus.read_ready     = 1'b1;
        bus.readdata_left  = l;
        bus.readdata_right = r;
        bus.bypass         = bp;
        bus.write_ready    = 1'b1;
        tick();
        bus.read_ready = 1'b0;
        tick();
        tick();
        bus.bypass = 1'b0;
    endtask

    // One zero-valued sample that times out; starts and ends in S_IDLE.
    task automatic drop_sample();
        bus.read_ready     = 1'b1;
        bus.readdata_left  = '0;
        bus.readdata_right = '0;
        bus.write_ready    = 1'b0;
        tick();
        bus.read_ready = 1'b0;
        repeat (9) tick();
    endtask

    initial begin
        bus.read_ready     = 1'b1;
        bus.readdata_left  = '0;
        bus.readdata_right = '0;
        bus.write_ready    = 1'b1;
        bus.bypass         = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        #1;
        chk("rst_read",   32'(bus.read), 32'h0);
        chk("rst_write",  32'(bus.write), 32'h0);
        chk("rst_filt",   32'(bus.filt_en), 32'h0);
        chk("rst_scnt",   32'(bus.sample_count), 32'h0);
        chk("rst_dcnt",   32'(bus.drop_count), 32'h0);
        chk("rst_wdat",   32'(bus.writedata_left), 32'h0);

        // ---- first sample: latency T / T+1 / T+2 ----
        reset              = 1'b0;
        bus.read_ready     = 1'b0;
        tick();
        clr_mon();
        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'h000100;
        bus.readdata_right = 24'h000200;
        #1;
        chk("t1_read_T",  32'(bus.read), 32'h1);
        chk("t1_fe_T",    32'(bus.filt_en), 32'h0);
        tick();
        bus.read_ready = 1'b0;
        #1;
        chk("t1_fe_T1",   32'(bus.filt_en), 32'h1);
        chk("t1_rd_T1",   32'(bus.read), 32'h0);
        chk("t1_fd_l",    32'(bus.filt_d_left), 32'h000100);
        chk("t1_fd_r",    32'(bus.filt_d_right), 32'h000200);
        tick();
        #1;
        chk("t1_wr_T2",   32'(bus.write), 32'h1);
        chk("t1_fe_T2",   32'(bus.filt_en), 32'h0);
        chk("t1_wd_l",    32'(bus.writedata_left), 32'h000020);
        chk("t1_wd_r",    32'(bus.writedata_right), 32'h000040);
        tick();
        #1;
        chk("t1_wr_T3",   32'(bus.write), 32'h0);
        chk("t1_scnt",    32'(bus.sample_count), 32'h1);
        chk("t1_nfe",     32'(n_fe), 32'h1);

        // ---- 10 back-to-back samples ----
        clr_mon();
        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'h000800;
        bus.readdata_right = 24'hFFF800;
        repeat (30) tick();
        bus.read_ready = 1'b0;
        tick();
        chk("t2_nrd",     32'(n_rd), 32'd10);
        chk("t2_nfe",     32'(n_fe), 32'd10);
        chk("t2_nwr",     32'(n_wr), 32'd10);
        chk("t2_both",    32'(n_both), 32'd0);
        chk("t2_scnt",    32'(bus.sample_count), 32'd11);
        chk("t2_wd_l",    32'(last_wl), 32'h000A20);
        chk("t2_wd_r",    32'(last_wr), 32'hFFF640);

        // ---- bypass, then history continuity ----
        clr_mon();
        run_sample(24'h7FFFFF, 24'h800000, 1'b1);
        chk("t3_wd_l",    32'(last_wl), 32'h7FFFFF);
        chk("t3_wd_r",    32'(last_wr), 32'h800000);
        chk("t3_nfe",     32'(n_fe), 32'd1);
        chk("t3_nwr",     32'(n_wr), 32'd1);
        run_sample(24'h000008, 24'h000000, 1'b0);
        chk("t3_hist_l",  32'(last_wl), 32'h100A20);
        chk("t3_hist_r",  32'(last_wr), 32'hEFF640);
        chk("t3_scnt",    32'(bus.sample_count), 32'd13);

        // ---- timeout drop after 8 stalled cycles ----
        clr_mon();
        bus.read_ready     = 1'b1;
        bus.readdata_left  = '0;
        bus.readdata_right = '0;
        bus.write_ready    = 1'b0;
        tick();
        bus.read_ready = 1'b0;
        repeat (8) tick();
        #1;
        chk("t4_dcnt_c8", 32'(bus.drop_count), 32'h0);
        tick();
        bus.write_ready = 1'b1;
        #1;
        chk("t4_dcnt",    32'(bus.drop_count), 32'h1);
        chk("t4_idle_wr", 32'(bus.write), 32'h0);
        chk("t4_nwr",     32'(n_wr), 32'd0);

        // ---- write_ready rising on the 8th stalled cycle ----
        clr_mon();
        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'h000010;
        bus.readdata_right = 24'h000018;
        bus.write_ready    = 1'b0;
        tick();
        bus.read_ready = 1'b0;
        repeat (8) tick();
        bus.write_ready = 1'b1;
        #1;
        chk("t4b_wr_c8",  32'(bus.write), 32'h1);
        tick();
        chk("t4b_dcnt",   32'(bus.drop_count), 32'h1);
        chk("t4b_scnt",   32'(bus.sample_count), 32'd14);
        chk("t4b_nwr",    32'(n_wr), 32'd1);
        chk("t4b_wd_l",   32'(last_wl), 32'h100A22);
        chk("t4b_wd_r",   32'(last_wr), 32'hEFF643);

        // ---- drop counter saturation ----
        for (int i = 0; i < 300; i++) begin
            drop_sample();
            if (i == 252) chk("t5_dcnt_fe", 32'(bus.drop_count), 32'hFE);
        end
        chk("t5_dcnt_sat", 32'(bus.drop_count), 32'hFF);
        chk("t5_scnt",     32'(bus.sample_count), 32'd14);

        // ---- reset during S_FILT ----
        clr_mon();
        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'h000040;
        bus.readdata_right = 24'h000040;
        bus.write_ready    = 1'b1;
        tick();
        bus.read_ready = 1'b0;
        reset          = 1'b1;
        #1;
        chk("t6a_fe",     32'(bus.filt_en), 32'h0);
        chk("t6a_wr",     32'(bus.write), 32'h0);
        tick();
        bus.read_ready = 1'b1;
        #1;
        chk("t6a_rd",     32'(bus.read), 32'h0);
        chk("t6a_scnt",   32'(bus.sample_count), 32'h0);
        chk("t6a_dcnt",   32'(bus.drop_count), 32'h0);
        chk("t6a_nfe",    32'(n_fe), 32'd0);
        reset          = 1'b0;
        bus.read_ready = 1'b0;
        tick();
        run_sample(24'h000008, 24'h000008, 1'b0);
        chk("t6a_wd_l",   32'(last_wl), 32'h100A23);
        chk("t6a_wd_r",   32'(last_wr), 32'hEFF644);
        chk("t6a_scnt2",  32'(bus.sample_count), 32'd1);

        // ---- reset during S_WRITE ----
        clr_mon();
        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'h000040;
        bus.readdata_right = 24'h000040;
        bus.write_ready    = 1'b0;
        tick();
        bus.read_ready = 1'b0;
        tick();
        reset           = 1'b1;
        bus.write_ready = 1'b1;
        #1;
        chk("t6b_wr",     32'(bus.write), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6b_idle_wr", 32'(bus.write), 32'h0);
        chk("t6b_scnt",   32'(bus.sample_count), 32'h0);
        chk("t6b_nwr",    32'(n_wr), 32'd0);
        run_sample(24'h000000, 24'h000000, 1'b0);
        chk("t6b_wd_l",   32'(last_wl), 32'h100A2B);
        chk("t6b_wd_r",   32'(last_wr), 32'hEFF64C);
        chk("t6b_scnt2",  32'(bus.sample_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
